layer_feed_ctrl: RTL and testbench

//  Driver side of the shift-layer load/start interface. Generates pseudo-random rows
//  (layer, block type, bonus) for the top of the layer chain. Fills the chain at power-up,

---
 rtl/layer_feed_ctrl_if.sv | 47 ++++
 rtl/layer_feed_ctrl.sv | 169 ++++++++++++++++
 tb/tb_layer_feed_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_feed_ctrl_if.sv
// Bundle between the layer feed controller and the game logic / layer stack.
// Carries the control inputs, the new-row bus and the load/start/status strobes.
// master = the feed controller, slave = game logic plus the layer scrollers.
interface layer_feed_ctrl_if;
    // control from game logic
    logic        module_en;
    logic        one_ms_tick;
    logic        scroll_req;
    // new row for the top layer; bit k of each vector is element k of the row
    logic [6:0]  layer_map_new;
    logic [6:0]  block_type_new;
    logic [6:0]  bonus_map_new;
    // strobes and status
    logic        load;
    logic        start;
    logic        busy;
    logic        scroll_done;
    logic [15:0] layer_count;

    modport master (
        input  module_en,
        input  one_ms_tick,
        input  scroll_req,
        output layer_map_new,
        output block_type_new,
        output bonus_map_new,
        output load,
        output start,
        output busy,
        output scroll_done,
        output layer_count
    );

    modport slave (
        output module_en,
        output one_ms_tick,
        output scroll_req,
        input  layer_map_new,
        input  block_type_new,
        input  bonus_map_new,
        input  load,
        input  start,
        input  busy,
        input  scroll_done,
        input  layer_count
    );
endinterface

// File: rtl/layer_feed_ctrl.sv
// Feeds pseudo-random rows to the top of the shift-layer chain: fills it after reset, then runs one timed scroll per request.
// Latency: start 1 cycle after an accepted request; scroll_done SETTLE_CYC cycles after the SCROLL_TICKS-th tick.
// Backpressure: scroll_req is only accepted in S_READY with module_en high; requests while busy are dropped, never queued.
module layer_feed_ctrl #(
    parameter int          NUM_LAYERS   = 5,
    parameter int          SCROLL_TICKS = 150,
    parameter int          SETTLE_CYC   = 2,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    layer_feed_ctrl_if.master fc
);

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [7:0]  FILL_LAST   = 8'(NUM_LAYERS - 1);
    localparam logic [15:0] TICK_LAST   = 16'(SCROLL_TICKS - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_READY,
        S_START,
        S_WAIT,
        S_SETTLE
    } state_t;

    typedef struct packed {
        logic [6:0] map;
        logic [6:0] typ;
        logic [6:0] bonus;
    } row_t;

    // Row derived from an LFSR value. An empty map is never sent: block 3 is forced
    // in so every row has at least one block. Bonus bits only exist where a block does.
    function automatic row_t row_gen(input logic [15:0] l);
        row_t r;
        r.map = l[6:0];
        if (r.map == 7'd0) begin
            r.map[3] = 1'b1;
        end
        r.typ   = l[6:0] ^ l[15:9];
        r.bonus = (l[15:14] == 2'b11) ? (r.map & l[13:7]) : 7'd0;
        return r;
    endfunction

    state_t      r_state;
    logic [15:0] r_lfsr;
    row_t        r_row;
    logic        r_fill_phase;   // 0: present row with load, 1: advance to next row
    logic [7:0]  r_fill_cnt;
    logic [15:0] r_tick_cnt;
    logic [7:0]  r_settle_cnt;
    logic        r_load;
    logic        r_start;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_layer_count;

    logic [15:0] w_lfsr_next;
    row_t        w_row_next;

    // Next LFSR state and the row it produces, used whenever a row is consumed.
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_row_next  = row_gen(w_lfsr_next);

    // Control FSM; all strobes and the row bus are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_lfsr        <= SEED_EFF;
            r_row         <= '0;
            r_fill_phase  <= 1'b0;
            r_fill_cnt    <= 8'd0;
            r_tick_cnt    <= 16'd0;
            r_settle_cnt  <= 8'd0;
            r_load        <= 1'b0;
            r_start       <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_layer_count <= 16'd0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            r_load  <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_FILL: begin
                    if (!r_fill_phase) begin
                        // Row for the current LFSR value goes out together with load.
                        // Only the very first fill step actually changes r_row here.
                        r_row        <= row_gen(r_lfsr);
                        r_load       <= 1'b1;
                        r_fill_phase <= 1'b1;
                    end else begin
                        r_fill_phase <= 1'b0;
                        r_lfsr       <= w_lfsr_next;
                        r_row        <= w_row_next;
                        if (r_fill_cnt == FILL_LAST) begin
                            r_fill_cnt <= 8'd0;
                            r_busy     <= 1'b0;
                            r_state    <= S_READY;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 8'd1;
                        end
                    end
                end

                S_READY: begin
                    // a tick arriving alongside the request is deliberately not counted
                    if (fc.scroll_req && fc.module_en) begin
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    // ticks seen while start is on the bus belong to no scroll
                    r_tick_cnt <= 16'd0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (fc.one_ms_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt   <= 16'd0;
                            r_settle_cnt <= 8'd0;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 16'd1;
                        end
                    end
                end

                S_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        // layers latch the old row at this edge, so the new one may appear now
                        r_lfsr        <= w_lfsr_next;
                        r_row         <= w_row_next;
                        r_done        <= 1'b1;
                        r_layer_count <= r_layer_count + 16'd1;
                        r_busy        <= 1'b0;
                        r_settle_cnt  <= 8'd0;
                        r_state       <= S_READY;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign fc.layer_map_new  = r_row.map;
    assign fc.block_type_new = r_row.typ;
    assign fc.bonus_map_new  = r_row.bonus;
    assign fc.load           = r_load;
    assign fc.start          = r_start;
    assign fc.busy           = r_busy;
    assign fc.scroll_done    = r_done;
    assign fc.layer_count    = r_layer_count;

endmodule

// File: tb/tb_layer_feed_ctrl.sv
// Bench for layer_feed_ctrl: reset, fill sequence, single and back-to-back scrolls,
// enable gating and reset during a scroll. Expected rows and counts come from a
// bench-side LFSR model and are held in scoreboard queues until the DUT produces them.
module tb_layer_feed_ctrl;

    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          NUM_LAYERS = 5;
    localparam int          TICKS      = 150;

    typedef struct packed {
        logic [6:0] map;
        logic [6:0] typ;
        logic [6:0] bonus;
    } row_t;

    typedef struct packed {
        row_t        row;
        logic [15:0] cnt;
    } scroll_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    layer_feed_ctrl_if fc();

    layer_feed_ctrl #(
        .NUM_LAYERS  (NUM_LAYERS),
        .SCROLL_TICKS(TICKS),
        .SETTLE_CYC  (2),
        .SEED        (SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fc (fc)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_count;
    row_t        fill_q[$];
    scroll_exp_t sb_q[$];

    function automatic logic [15:0] m_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic row_t row_model(input logic [15:0] l);
        row_t r;
        r = '0;
        for (int k = 0; k < 7; k++) begin
            r.map[k] = l[k];
            r.typ[k] = l[k] ^ l[k+9];
        end
        if (r.map == 7'd0) r.map[3] = 1'b1;
        if (l[15] && l[14]) begin
            for (int k = 0; k < 7; k++) r.bonus[k] = r.map[k] & l[k+7];
        end
        return r;
    endfunction

    function automatic row_t dut_row();
        row_t r;
        r.map   = fc.layer_map_new;
        r.typ   = fc.block_type_new;
        r.bonus = fc.bonus_map_new;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fc.module_en   = 1'b0;
        fc.one_ms_tick = 1'b0;
        fc.scroll_req  = 1'b0;
        step();
        step();
        n_checks++;
        if ({fc.load, fc.start, fc.busy, fc.scroll_done} !== 4'b0010)
            $display("FAIL reset_strobes: got %b want 0010", {fc.load, fc.start, fc.busy, fc.scroll_done});
        else n_pass++;
        n_checks++;
        if (fc.layer_count !== 16'd0)
            $display("FAIL reset_count: got %0d want 0", fc.layer_count);
        else n_pass++;
        n_checks++;
        if (dut_row() !== 21'd0)
            $display("FAIL reset_row: got %h want 0", dut_row());
        else n_pass++;
        rst     = 1'b0;
        m_lfsr  = SEED;
        m_count = 16'd0;
        fill_q.delete();
        sb_q.delete();
    endtask

    task automatic test_fill(input bit check_t1);
        int   nload;
        int   last;
        int   gap_bad;
        int   start_seen;
        row_t t1_row;
        row_t exp_row;
        t1_row     = {7'b1100001, 7'b0110111, 7'b0000000};
        nload      = 0;
        last       = 0;
        gap_bad    = 0;
        start_seen = 0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            fill_q.push_back(row_model(m_lfsr));
            m_lfsr = m_next(m_lfsr);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (fc.start === 1'b1) start_seen++;
            if (fc.load === 1'b1) begin
                if (nload > 0 && cyc - last != 2) gap_bad++;
                last = cyc;
                if (check_t1 && nload == 0) begin
                    n_checks++;
                    if (dut_row() !== t1_row)
                        $display("FAIL first_row_seed: got %h want %h", dut_row(), t1_row);
                    else n_pass++;
                end
                exp_row = (fill_q.size() > 0) ? fill_q.pop_front() : 21'd0;
                n_checks++;
                if (dut_row() !== exp_row)
                    $display("FAIL fill_row%0d: got %h want %h", nload, dut_row(), exp_row);
                else n_pass++;
                nload++;
            end
            if (fc.busy === 1'b0) break;
        end
        n_checks++;
        if (nload !== NUM_LAYERS) $display("FAIL fill_loads: got %0d want %0d", nload, NUM_LAYERS);
        else n_pass++;
        n_checks++;
        if (gap_bad !== 0) $display("FAIL fill_spacing: got %0d bad gaps want 0", gap_bad);
        else n_pass++;
        n_checks++;
        if (start_seen !== 0) $display("FAIL fill_no_start: got %0d starts want 0", start_seen);
        else n_pass++;
        n_checks++;
        if (fc.busy !== 1'b0) $display("FAIL fill_ready: busy got %b want 0", fc.busy);
        else n_pass++;
        n_checks++;
        if (dut_row() !== row_model(m_lfsr))
            $display("FAIL ready_row: got %h want %h", dut_row(), row_model(m_lfsr));
        else n_pass++;
    endtask

    // One complete scroll from request to done. keep_req leaves scroll_req high
    // afterwards; tick_on_req drives a tick in the same cycle as the request.
    task automatic do_scroll(input bit keep_req, input bit tick_on_req);
        row_t        cur;
        scroll_exp_t e;
        scroll_exp_t got_e;
        int          extra_start;
        int          early;
        int          unstable;
        int          n;
        cur         = row_model(m_lfsr);
        m_lfsr      = m_next(m_lfsr);
        m_count     = m_count + 16'd1;
        e.row       = row_model(m_lfsr);
        e.cnt       = m_count;
        sb_q.push_back(e);
        extra_start = 0;
        early       = 0;
        unstable    = 0;

        fc.scroll_req  = 1'b1;
        fc.one_ms_tick = tick_on_req;
        step();
        fc.one_ms_tick = 1'b0;
        if (!keep_req) fc.scroll_req = 1'b0;
        n_checks++;
        if ({fc.start, fc.busy, fc.load} !== 3'b110)
            $display("FAIL start_latency: start/busy/load got %b want 110", {fc.start, fc.busy, fc.load});
        else n_pass++;

        // tick during the start cycle must not count
        fc.one_ms_tick = 1'b1;
        step();
        fc.one_ms_tick = 1'b0;
        for (int t = 0; t < TICKS; t++) begin
            if (t > 0) begin
                for (int g = 0; g < 2; g++) begin
                    step();
                    if (fc.start === 1'b1) extra_start++;
                    if (fc.scroll_done === 1'b1) early++;
                    if (dut_row() !== cur) unstable++;
                end
            end
            fc.one_ms_tick = 1'b1;
            step();
            fc.one_ms_tick = 1'b0;
            if (fc.start === 1'b1) extra_start++;
            if (fc.scroll_done === 1'b1) early++;
            if (dut_row() !== cur) unstable++;
        end
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (fc.scroll_done === 1'b1) break;
            if (fc.start === 1'b1) extra_start++;
            if (dut_row() !== cur) unstable++;
        end
        n_checks++;
        if (n !== 2) $display("FAIL settle_cycles: done after %0d cycles want 2", n);
        else n_pass++;
        n_checks++;
        if (extra_start !== 0) $display("FAIL extra_start: got %0d want 0", extra_start);
        else n_pass++;
        n_checks++;
        if (early !== 0) $display("FAIL early_done: got %0d want 0", early);
        else n_pass++;
        n_checks++;
        if (unstable !== 0) $display("FAIL row_stable: got %0d changed cycles want 0", unstable);
        else n_pass++;
        got_e.row = dut_row();
        got_e.cnt = fc.layer_count;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (got_e.row !== e.row) $display("FAIL done_row: got %h want %h", got_e.row, e.row);
        else n_pass++;
        n_checks++;
        if (got_e.cnt !== e.cnt) $display("FAIL layer_count: got %0d want %0d", got_e.cnt, e.cnt);
        else n_pass++;
        n_checks++;
        if (fc.busy !== 1'b0) $display("FAIL done_busy: got %b want 0", fc.busy);
        else n_pass++;
    endtask

    task automatic test_single_scroll();
        int bad;
        fc.module_en = 1'b1;
        do_scroll(1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fc.start !== 1'b0 || fc.busy !== 1'b0 || fc.scroll_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL idle_after_done: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad;
        do_scroll(1'b1, 1'b0);
        do_scroll(1'b0, 1'b1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fc.start !== 1'b0 || fc.busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL b2b_idle: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_enable();
        int bad;
        fc.module_en  = 1'b0;
        fc.scroll_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fc.start !== 1'b0 || fc.busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL disabled_req: got %0d bad cycles want 0", bad);
        else n_pass++;
        fc.module_en = 1'b1;
        do_scroll(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        fc.scroll_req = 1'b1;
        step();
        fc.scroll_req = 1'b0;
        n_checks++;
        if (fc.start !== 1'b1) $display("FAIL mid_start: got %b want 1", fc.start);
        else n_pass++;
        step();
        for (int t = 0; t < 70; t++) begin
            fc.one_ms_tick = 1'b1;
            step();
            fc.one_ms_tick = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({fc.load, fc.start, fc.busy, fc.scroll_done} !== 4'b0010)
            $display("FAIL mid_reset_strobes: got %b want 0010", {fc.load, fc.start, fc.busy, fc.scroll_done});
        else n_pass++;
        n_checks++;
        if (fc.layer_count !== 16'd0) $display("FAIL mid_reset_count: got %0d want 0", fc.layer_count);
        else n_pass++;
        rst     = 1'b0;
        m_lfsr  = SEED;
        m_count = 16'd0;
        fill_q.delete();
        sb_q.delete();
        test_fill(1'b1);
        n_checks++;
        if (fc.layer_count !== 16'd0) $display("FAIL refill_count: got %0d want 0", fc.layer_count);
        else n_pass++;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill(1'b1);
        test_single_scroll();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
